// File: rtl/frame_wr_ctrl_pkg.sv
// Frame-buffer shared definitions: beat sizing, state encoding and helpers.
// Used by both the write-side and read-side frame controllers.
package frame_wr_ctrl_pkg;

    localparam int AXI_DATA_WIDTH_DEF = 256;
    localparam int AXI_BYTES          = AXI_DATA_WIDTH_DEF / 8;
    localparam int BEAT_W             = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_DATA,
        ST_REQ,
        ST_WAIT_DONE,
        ST_SWITCH
    } fb_state_e;

    function automatic int axi_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/frame_beat_calc.sv
// Frame sizing: beats per line (ceil of line bytes over beat bytes) and beats
// per frame, registered once when load is asserted.
module frame_beat_calc
    import frame_wr_ctrl_pkg::*;
#(
    parameter int VID_DATA_WIDTH = 16,
    parameter int BYTES_PER_BEAT = AXI_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [10:0]       width,
    input  logic [10:0]       height,
    output logic [BEAT_W-1:0] line_beats,
    output logic [BEAT_W-1:0] total_beats
);

    logic [31:0]       line_bytes;
    logic [BEAT_W-1:0] lb_c;
    logic [BEAT_W-1:0] tb_c;

    assign line_bytes = ({21'd0, width} * 32'(VID_DATA_WIDTH)) >> 3;
    assign lb_c       = BEAT_W'((line_bytes + 32'(BYTES_PER_BEAT - 1)) / 32'(BYTES_PER_BEAT));
    assign tb_c       = lb_c * BEAT_W'(height);

    always_ff @(posedge clk) begin
        if (rst) begin
            line_beats  <= '0;
            total_beats <= '0;
        end else if (load) begin
            line_beats  <= lb_c;
            total_beats <= tb_c;
        end
    end

endmodule

// File: rtl/frame_wr_ctrl.sv
// Write-side frame controller: slices each frame into FIFO-paced AXI write
// bursts from the current bank base, then requests a write-bank switch.
module frame_wr_ctrl
    import frame_wr_ctrl_pkg::*;
#(
    parameter int VID_DATA_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int BURST_LEN      = 64,
    parameter int CNT_W          = 12
) (
    input  logic             ddr_clk,
    input  logic             rst,
    input  logic [10:0]      MAX_VID_WIDTH,
    input  logic [10:0]      MAX_VID_HIGHT,
    input  logic             frame_start,
    input  logic [31:0]      wr_start_addr,
    output logic             wr_sw,
    input  logic             wr_sw_ack,
    input  logic [CNT_W-1:0] fifo_rd_cnt,
    output logic             burst_req,
    input  logic             burst_ready,
    output logic [31:0]      burst_addr,
    output logic [7:0]       burst_len,
    input  logic             burst_done,
    output logic             frame_done,
    output logic             frame_skip,
    output logic             busy
);

    localparam int                BYTES     = axi_bytes(AXI_DATA_WIDTH);
    localparam logic [BEAT_W-1:0] BURST_MAX = BEAT_W'(BURST_LEN);

    fb_state_e         state, state_nx;
    logic [31:0]       cur_addr;
    logic [BEAT_W-1:0] remaining, line_beats, total_beats, n_beats;
    logic [8:0]        n_reg;
    logic              load, data_ok, hs, empty_frame;
    logic              req_d, sw_d, busy_d, done_d, skip_d;

    assign load        = (state == ST_IDLE) && frame_start;
    assign n_beats     = (remaining < BURST_MAX) ? remaining : BURST_MAX;
    assign data_ok     = BEAT_W'(fifo_rd_cnt) >= n_beats;
    assign hs          = (state == ST_REQ) && burst_ready;
    assign empty_frame = (line_beats == '0) || (total_beats == '0);

    frame_beat_calc #(
        .VID_DATA_WIDTH (VID_DATA_WIDTH),
        .BYTES_PER_BEAT (BYTES)
    ) u_calc (
        .clk         (ddr_clk),
        .rst         (rst),
        .load        (load),
        .width       (MAX_VID_WIDTH),
        .height      (MAX_VID_HIGHT),
        .line_beats  (line_beats),
        .total_beats (total_beats)
    );

    always_ff @(posedge ddr_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (frame_start) state_nx = ST_CALC;
            ST_CALC:      state_nx = empty_frame ? ST_SWITCH : ST_WAIT_DATA;
            ST_WAIT_DATA: if (data_ok) state_nx = ST_REQ;
            ST_REQ:       if (burst_ready) state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: if (burst_done) state_nx = (remaining != '0) ? ST_WAIT_DATA : ST_SWITCH;
            ST_SWITCH:    if (wr_sw_ack) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so nothing
    // combinational reaches a port.
    always_comb begin
        req_d  = (state_nx == ST_REQ);
        sw_d   = (state_nx == ST_SWITCH);
        busy_d = (state_nx != ST_IDLE);
        done_d = (state == ST_SWITCH) && wr_sw_ack;
        skip_d = (state != ST_IDLE) && frame_start;
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            burst_req  <= 1'b0;
            wr_sw      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_skip <= 1'b0;
        end else begin
            burst_req  <= req_d;
            wr_sw      <= sw_d;
            busy       <= busy_d;
            frame_done <= done_d;
            frame_skip <= skip_d;
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            cur_addr   <= '0;
            remaining  <= '0;
            n_reg      <= '0;
            burst_addr <= '0;
            burst_len  <= '0;
        end else begin
            if (load)
                cur_addr <= wr_start_addr;
            if (state == ST_CALC)
                remaining <= total_beats;
            if (state == ST_WAIT_DATA && data_ok) begin
                burst_addr <= cur_addr;
                burst_len  <= 8'(n_beats - 1'b1);
                n_reg      <= 9'(n_beats);
            end
            // Linear addressing; the 32-bit add wraps naturally.
            if (hs) begin
                cur_addr  <= cur_addr + 32'(n_reg) * 32'(BYTES);
                remaining <= remaining - BEAT_W'(n_reg);
            end
        end
    end

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// Bench for frame_wr_ctrl: table of frame configs, hand-written corner
// sequences and random frames checked against a burst-list model.
module tb_frame_wr_ctrl;

    localparam int VID = 16;
    localparam int AXW = 256;
    localparam int AB  = AXW / 8;
    localparam int BL  = 8;
    localparam int CW  = 12;

    logic          ddr_clk = 1'b0;
    logic          rst = 1'b1;
    logic [10:0]   MAX_VID_WIDTH = '0, MAX_VID_HIGHT = '0;
    logic          frame_start = 1'b0, wr_sw_ack = 1'b0, burst_ready = 1'b0, burst_done = 1'b0;
    logic [31:0]   wr_start_addr = '0;
    logic [CW-1:0] fifo_rd_cnt = '0;
    logic          wr_sw, burst_req, frame_done, frame_skip, busy;
    logic [31:0]   burst_addr;
    logic [7:0]    burst_len;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] obs_a[$], exp_a[$];
    logic [7:0]  obs_l[$], exp_l[$];

    typedef struct {
        int          w, h;
        logic [31:0] base;
        int          rdy, ack, skip;
        int          bursts;
        logic [31:0] last_a;
        logic [7:0]  last_l;
        int          skips;
    } vec_t;

    frame_wr_ctrl #(
        .VID_DATA_WIDTH (VID),
        .AXI_DATA_WIDTH (AXW),
        .BURST_LEN      (BL),
        .CNT_W          (CW)
    ) dut (
        .ddr_clk       (ddr_clk),
        .rst           (rst),
        .MAX_VID_WIDTH (MAX_VID_WIDTH),
        .MAX_VID_HIGHT (MAX_VID_HIGHT),
        .frame_start   (frame_start),
        .wr_start_addr (wr_start_addr),
        .wr_sw         (wr_sw),
        .wr_sw_ack     (wr_sw_ack),
        .fifo_rd_cnt   (fifo_rd_cnt),
        .burst_req     (burst_req),
        .burst_ready   (burst_ready),
        .burst_addr    (burst_addr),
        .burst_len     (burst_len),
        .burst_done    (burst_done),
        .frame_done    (frame_done),
        .frame_skip    (frame_skip),
        .busy          (busy)
    );

    always #5 ddr_clk = ~ddr_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    // Expected burst list straight from the frame geometry.
    task automatic build_model(input int w, input int h, input logic [31:0] base);
        int unsigned beats, n;
        logic [31:0] a;
        exp_a.delete();
        exp_l.delete();
        beats = ((w * VID / 8 + AB - 1) / AB) * h;
        a = base;
        while (beats > 0) begin
            n = (beats > BL) ? BL : beats;
            exp_a.push_back(a);
            exp_l.push_back(8'(n - 1));
            a = a + 32'(n * AB);
            beats -= n;
        end
    endtask

    // Runs one frame as AXI master + FIFO + bank switcher; records bursts.
    task automatic do_frame(input int w, input int h, input logic [31:0] base,
                            input int rdy, input int ack, input int skip,
                            output logic [1:0] fd, output int skips, output int hold_bad,
                            output int lat_bad, output int first_lat, output bit to);
        int cyc = 0, wc = 0, last_done = -1;
        bit pend = 0, acked = 0, sw_seen = 0;
        logic [31:0] ha = '0;
        logic [7:0]  hl = '0;
        obs_a.delete();
        obs_l.delete();
        fd = 2'b00; skips = 0; hold_bad = 0; lat_bad = 0; first_lat = -1; to = 1;
        fifo_rd_cnt   = '1;
        MAX_VID_WIDTH = 11'(w);
        MAX_VID_HIGHT = 11'(h);
        wr_start_addr = base;
        frame_start   = 1'b1;
        while (cyc < 4000) begin
            tick();
            cyc++;
            frame_start = 0; burst_ready = 0; burst_done = 0; wr_sw_ack = 0;
            if (frame_skip) skips++;
            if (acked) begin
                fd[1] = frame_done;
                tick();
                fd[0] = frame_done;
                if (frame_skip) skips++;
                to = 0;
                break;
            end
            if (burst_req && !pend) begin
                if (wc == 0) begin
                    ha = burst_addr;
                    hl = burst_len;
                    if (first_lat < 0) first_lat = cyc;
                    if (last_done >= 0 && cyc - last_done != 2) lat_bad++;
                    last_done = -1;
                end else if (burst_addr !== ha || burst_len !== hl) begin
                    hold_bad++;
                end
                if (wc >= rdy) begin
                    burst_ready = 1'b1;
                    obs_a.push_back(burst_addr);
                    obs_l.push_back(burst_len);
                    pend = 1; wc = 0;
                end else wc++;
            end else if (pend) begin
                if (wc >= 2) begin
                    burst_done = 1'b1;
                    last_done = cyc;
                    pend = 0; wc = 0;
                end else wc++;
            end else if (wr_sw) begin
                if (!sw_seen) begin
                    sw_seen = 1;
                    if (last_done >= 0 && cyc - last_done != 1) lat_bad++;
                end
                if (wc == skip) frame_start = 1'b1;
                if (wc >= ack) begin
                    wr_sw_ack = 1'b1;
                    acked = 1;
                end else wc++;
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        logic [1:0] fd;
        int skips, hold_bad, lat_bad, first_lat, cnt;
        bit to;

        vecs[0] = '{64,   4, 32'h0000_1000, 0,  2, -1,  2, 32'h0000_1100, 8'd7, 0};
        vecs[1] = '{48,   1, 32'h0000_2000, 10, 0, -1,  1, 32'h0000_2000, 8'd2, 0};
        vecs[2] = '{100,  2, 32'hFFFF_FF00, 1, 50, 20,  2, 32'h0000_0000, 8'd5, 1};
        vecs[3] = '{0,    5, 32'h0000_3000, 0,  3, -1,  0, 32'h0,         8'd0, 0};
        vecs[4] = '{17,   3, 32'h0000_0040, 0,  4,  4,  1, 32'h0000_0040, 8'd5, 1};
        vecs[5] = '{16,   0, 32'h0000_0050, 0,  1, -1,  0, 32'h0,         8'd0, 0};
        vecs[6] = '{2047, 1, 32'h0010_0000, 0,  0, -1, 16, 32'h0010_0F00, 8'd7, 0};

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(burst_req), 32'd0);
        chk("rst_wr_sw", 32'(wr_sw), 32'd0);
        chk("rst_addr", burst_addr, 32'd0);
        chk("rst_len", 32'(burst_len), 32'd0);
        chk("rst_done_skip", {30'd0, frame_done, frame_skip}, 32'd0);
        rst = 1'b0;
        tick();

        // Stray burst_done while idle must not start anything
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        tick();
        chk("idle_done_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_frame(vecs[i].w, vecs[i].h, vecs[i].base, vecs[i].rdy, vecs[i].ack, vecs[i].skip,
                     fd, skips, hold_bad, lat_bad, first_lat, to);
            chk($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
            chk($sformatf("v%0d_nbursts", i), 32'(obs_a.size()), 32'(vecs[i].bursts));
            if (vecs[i].bursts > 0 && obs_a.size() > 0) begin
                chk($sformatf("v%0d_last_addr", i), obs_a[obs_a.size()-1], vecs[i].last_a);
                chk($sformatf("v%0d_last_len", i), 32'(obs_l[obs_l.size()-1]), 32'(vecs[i].last_l));
                chk($sformatf("v%0d_first_addr", i), obs_a[0], vecs[i].base);
                chk($sformatf("v%0d_start_to_req", i), 32'(first_lat), 32'd3);
            end
            chk($sformatf("v%0d_frame_done", i), 32'(fd), 32'b10);
            chk($sformatf("v%0d_skips", i), 32'(skips), 32'(vecs[i].skips));
            chk($sformatf("v%0d_hold", i), 32'(hold_bad), 32'd0);
            chk($sformatf("v%0d_latency", i), 32'(lat_bad), 32'd0);
            chk($sformatf("v%0d_idle_after", i), 32'(busy), 32'd0);
        end

        // FIFO pacing: 3-beat frame must wait while fewer than 3 beats are buffered
        fifo_rd_cnt = 12'd2;
        MAX_VID_WIDTH = 11'd48; MAX_VID_HIGHT = 11'd1;
        wr_start_addr = 32'h0000_2000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (burst_req) cnt++;
        end
        chk("pace_no_req", 32'(cnt), 32'd0);
        fifo_rd_cnt = 12'd3;
        tick();
        chk("pace_req", 32'(burst_req), 32'd1);
        chk("pace_len", 32'(burst_len), 32'd2);
        chk("pace_addr", burst_addr, 32'h0000_2000);
        burst_ready = 1'b1;
        tick();
        burst_ready = 1'b0;
        chk("pace_req_drop", 32'(burst_req), 32'd0);
        tick();
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        chk("pace_wr_sw", 32'(wr_sw), 32'd1);
        wr_sw_ack = 1'b1;
        tick();
        wr_sw_ack = 1'b0;
        chk("pace_fdone", {30'd0, frame_done, wr_sw}, 32'b10);
        tick();
        chk("pace_fdone_once", {30'd0, frame_done, busy}, 32'b00);

        // Reset while a burst request is pending, then a fresh frame
        fifo_rd_cnt = '1;
        MAX_VID_WIDTH = 11'd64; MAX_VID_HIGHT = 11'd4;
        wr_start_addr = 32'h0000_4000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cnt = 0;
        while (!burst_req && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("rst_mid_reached_req", 32'(burst_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_req", 32'(burst_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addr", burst_addr, 32'd0);
        build_model(64, 4, 32'h0000_8000);
        do_frame(64, 4, 32'h0000_8000, 0, 1, -1, fd, skips, hold_bad, lat_bad, first_lat, to);
        chk("rst_restart_timeout", 32'(to), 32'd0);
        chk("rst_restart_n", 32'(obs_a.size()), 32'(exp_a.size()));
        for (int k = 0; k < obs_a.size() && k < exp_a.size(); k++)
            chk($sformatf("rst_restart_addr%0d", k), obs_a[k], exp_a[k]);

        // Random frames against the burst-list model
        for (int r = 0; r < 25; r++) begin
            int w, h, rdy, ack, skp;
            logic [31:0] base;
            w    = int'($urandom_range(0, 300));
            h    = int'($urandom_range(0, 6));
            base = $urandom;
            rdy  = int'($urandom_range(0, 3));
            ack  = int'($urandom_range(0, 5));
            skp  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1;
            build_model(w, h, base);
            do_frame(w, h, base, rdy, ack, skp, fd, skips, hold_bad, lat_bad, first_lat, to);
            chk($sformatf("r%0d_timeout", r), 32'(to), 32'd0);
            chk($sformatf("r%0d_n", r), 32'(obs_a.size()), 32'(exp_a.size()));
            for (int k = 0; k < obs_a.size() && k < exp_a.size(); k++) begin
                chk($sformatf("r%0d_addr%0d", r, k), obs_a[k], exp_a[k]);
                chk($sformatf("r%0d_len%0d", r, k), 32'(obs_l[k]), 32'(exp_l[k]));
            end
            chk($sformatf("r%0d_fdone", r), 32'(fd), 32'b10);
            chk($sformatf("r%0d_skips", r), 32'(skips), (skp >= 0 && skp <= ack) ? 32'd1 : 32'd0);
            chk($sformatf("r%0d_latency", r), 32'(lat_bad + hold_bad), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
